matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 80 ++++++++
 tb/tb_matrix_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Loads a full set of hash matrices row by row into a shadow register and
// commits the set atomically, so the hash datapath never sees a partial load.
module matrix_loader #(
  parameter int NUMBER_OF_TABLES = 4,
  parameter int HASH_ADR_WIDTH   = 5,
  parameter int KEY_WIDTH        = 2,
  localparam int R  = NUMBER_OF_TABLES * HASH_ADR_WIDTH,
  localparam int W  = R * KEY_WIDTH,
  localparam int CW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] row_i,
  input  logic                 row_valid_i,
  output logic                 row_ready_o,
  output logic [W-1:0]         matrixes_o,
  output logic                 matrixes_valid_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   shadow;
  logic           accept, commit, last;

  assign last        = (cnt == CW'(R - 1));
  assign row_ready_o = (state == LOAD);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:   if (start_i) state_nxt = LOAD;
      LOAD: begin
        // start_i wins over a valid row: the load restarts from row 0
        if (!start_i && row_valid_i) begin
          accept = 1'b1;
          if (last) state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = start_i ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt              <= '0;
      shadow           <= '0;
      matrixes_o       <= '0;
      matrixes_valid_o <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      done_o <= commit;
      if (commit) begin
        matrixes_o       <= shadow;
        matrixes_valid_o <= 1'b1;
      end
      if (start_i)     cnt <= '0;
      else if (accept) cnt <= last ? '0 : cnt + CW'(1);
      for (int r = 0; r < R; r++)
        if (accept && cnt == CW'(r)) shadow[r*KEY_WIDTH +: KEY_WIDTH] <= row_i;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader at default parameters (20 rows, 40-bit set).
module tb_matrix_loader;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  row_i;
  logic        row_valid_i;
  logic        row_ready_o;
  logic [39:0] matrixes_o;
  logic        matrixes_valid_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  // rows r%4 and 3-(r%4), packed two bits per row, row 0 in the LSBs
  localparam logic [39:0] SET_A = 40'hE4E4E4E4E4;
  localparam logic [39:0] SET_B = 40'h1B1B1B1B1B;

  matrix_loader dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .row_i            (row_i),
    .row_valid_i      (row_valid_i),
    .row_ready_o      (row_ready_o),
    .matrixes_o       (matrixes_o),
    .matrixes_valid_o (matrixes_valid_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // handshake seen before the edge, done seen after it
  task automatic step();
    if (row_ready_o && row_valid_i && !start_i) acc_cnt++;
    @(posedge clk);
    #1;
    if (done_o) done_cnt++;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic feed(input int mode, input int first, input int last_row, input bit gaps);
    for (int r = first; r <= last_row; r++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          row_valid_i = 1'b0;
          row_i = 2'($urandom_range(0, 3));
          step();
        end
      end
      row_i = (mode == 0) ? 2'(r % 4) : 2'(3 - (r % 4));
      row_valid_i = 1'b1;
      step();
    end
    row_valid_i = 1'b0;
  endtask

  // called right after the last row's edge; checks the COMMIT cycle and done pulse
  task automatic commit_seq(input string tag, input logic [39:0] old_set, input logic [39:0] new_set);
    check({tag, "_commit_busy"}, 64'(busy_o), 64'd1);
    check({tag, "_commit_ready"}, 64'(row_ready_o), 64'd0);
    check({tag, "_commit_done"}, 64'(done_o), 64'd0);
    check({tag, "_commit_old"}, 64'(matrixes_o), 64'(old_set));
    step();
    check({tag, "_done_hi"}, 64'(done_o), 64'd1);
    check({tag, "_mat"}, 64'(matrixes_o), 64'(new_set));
    check({tag, "_mvalid"}, 64'(matrixes_valid_o), 64'd1);
    check({tag, "_busy_lo"}, 64'(busy_o), 64'd0);
    step();
    check({tag, "_done_lo"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start_i = 1'b0; row_i = 2'd0; row_valid_i = 1'b0;
    step(); step();
    check("rst_mat", 64'(matrixes_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    reset = 1'b0;
    step();
    check("rel_mat", 64'(matrixes_o), 64'd0);
    check("rel_mvalid", 64'(matrixes_valid_o), 64'd0);
    check("rel_ready", 64'(row_ready_o), 64'd0);
    check("rel_busy", 64'(busy_o), 64'd0);
    check("rel_done", 64'(done_o), 64'd0);

    // contiguous load of set A
    start_pulse();
    check("a_ready", 64'(row_ready_o), 64'd1);
    acc_cnt = 0; d0 = done_cnt;
    feed(0, 0, 19, 1'b0);
    commit_seq("a", 40'h0, SET_A);
    check("a_bits1_0", 64'(matrixes_o[1:0]), 64'd0);
    check("a_bits7_6", 64'(matrixes_o[7:6]), 64'd3);
    check("a_bits39_38", 64'(matrixes_o[39:38]), 64'd3);
    check("a_accepts", 64'(acc_cnt), 64'd20);
    check("a_done_cnt", 64'(done_cnt - d0), 64'd1);

    // rows offered while idle are ignored
    row_valid_i = 1'b1; row_i = 2'd1;
    step(); step();
    check("idle_ready", 64'(row_ready_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_mat", 64'(matrixes_o), 64'(SET_A));
    row_valid_i = 1'b0;

    // same set with gapped valid
    start_pulse();
    acc_cnt = 0; d0 = done_cnt;
    feed(0, 0, 19, 1'b1);
    commit_seq("gap", SET_A, SET_A);
    check("gap_accepts", 64'(acc_cnt), 64'd20);
    check("gap_done_cnt", 64'(done_cnt - d0), 64'd1);

    // abort at row 10, then full set B
    start_pulse();
    d0 = done_cnt;
    feed(1, 0, 9, 1'b0);
    row_i = 2'd0; row_valid_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0; row_valid_i = 1'b0;
    check("abort_ready", 64'(row_ready_o), 64'd1);
    check("abort_mat", 64'(matrixes_o), 64'(SET_A));
    feed(1, 0, 18, 1'b0);
    check("abort_partial_mat", 64'(matrixes_o), 64'(SET_A));
    check("abort_partial_busy", 64'(busy_o), 64'd1);
    feed(1, 19, 19, 1'b0);
    commit_seq("b", SET_A, SET_B);
    check("b_done_cnt", 64'(done_cnt - d0), 64'd1);

    // start held in COMMIT goes straight back to LOAD
    start_pulse();
    d0 = done_cnt;
    feed(0, 0, 19, 1'b0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("rs_done", 64'(done_o), 64'd1);
    check("rs_mat", 64'(matrixes_o), 64'(SET_A));
    check("rs_ready", 64'(row_ready_o), 64'd1);
    check("rs_busy", 64'(busy_o), 64'd1);
    step();
    check("rs_done_lo", 64'(done_o), 64'd0);
    check("rs_ready2", 64'(row_ready_o), 64'd1);
    feed(1, 0, 19, 1'b0);
    commit_seq("rs_b", SET_A, SET_B);
    check("rs_done_cnt", 64'(done_cnt - d0), 64'd2);

    // asynchronous reset after 7 rows
    start_pulse();
    d0 = done_cnt;
    feed(0, 0, 6, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_mat", 64'(matrixes_o), 64'd0);
    check("arst_mvalid", 64'(matrixes_valid_o), 64'd0);
    check("arst_ready", 64'(row_ready_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_done", 64'(done_o), 64'd0);
    step();
    reset = 1'b0;
    step(); step(); step();
    check("arst_no_done", 64'(done_cnt - d0), 64'd0);
    check("arst_idle", 64'(busy_o), 64'd0);
    start_pulse();
    feed(0, 0, 19, 1'b0);
    commit_seq("post", 40'h0, SET_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
